decode_pipe: RTL and testbench
==============================

# decode_pipe

Parametrised instruction-decode stage with integrated register file and ID/EX pipeline register. Splits a 32-bit instruction into opcode, operands and immediate, reads source registers, and registers the result behind a valid/ready handshake. Adds what the first-generation decoder lacked: reset, back-pressure, flush, load-use hazard stall, r0 hardwired to zero, sign-extended immediates, and optional write-back bypass. Sits between fetch (IF/ID) and execute; write-back port fed from the WB stage.

## Interface
Parameters:
- DW, 32, datapath width; must be ≥ 32
- RAW, 5, register address width; register count NREG = 2**RAW; RAW ≤ 5, since each instruction register field is 5 bits

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  IF/ID holds a valid instruction
- in_ready  out  1  stage accepts instruction this cycle
- ir  in  32  instruction word
- npc_in  in  DW  next-PC of instruction
- flush  in  1  kill the incoming instruction and the held output
- out_valid  out  1  ID/EX contents valid
- out_ready  in  1  execute accepts ID/EX contents
- op  out  6  opcode ir[31:26]
- a, b  out  DW  operand values
- imm  out  DW  immediate
- npc_out  out  DW  registered npc_in
- rd  out  RAW  destination ir[21 +: RAW] (Ri field, bits 25:21)
- wb_en  in  1  register write enable
- wb_addr  in  RAW  write address
- wb_data  in  DW  write data

## Operation
- Fields: Ri=ir[25:21], Rj=ir[20:16], Rk=ir[15:11]; each truncated to its low RAW bits when RAW < 5
- Operand select by op:
  - op[5:4]=00 (R-R ALU): a=R[Rj], b=R[Rk], imm=0
  - op[5:4]=01 (memory; LW=6'b01_0000, SW=6'b01_0001): a=R[Ri], b=R[Rj], imm=sext(ir[15:0])
  - op=6'b10_0000 (BEQ): a=R[Ri], b=R[Rj], imm=sext(ir[15:0])
  - op=6'b10_0001 (JMP): a=b=0, imm=zext(ir[25:0])
  - all others: a=b=imm=0
- Register file: NREG×DW. R[0] always reads 0; writes to address 0 are ignored. Write occurs on the rising edge when wb_en=1.
- Load-use hazard (hz): out_valid=1, op(held)=LW, rd(held)≠0, and rd(held) equals a source register actually used by the incoming op: Rj/Rk for R-R; Ri/Rj for memory/BEQ; none for JMP
- in_ready = flush | ((!out_valid | out_ready) & !hz)
- ID/EX update, in priority order:
  - flush: out_valid←0; incoming instruction discarded
  - in_valid & in_ready: load all outputs, out_valid←1
  - out_ready & out_valid (no accept, e.g. hz): out_valid←0 (bubble)
  - otherwise: hold all outputs
- Data outputs change only on accept. When out_valid=0, data outputs are don't-care.

## Timing
- Latency: instruction accepted on edge N appears on outputs after edge N, with out_valid=1
- Throughput: 1 instruction/cycle when out_ready=1 and no hazard
- hz costs exactly one bubble: the LW drains, out_valid falls, and the dependent instruction is accepted the following cycle
- Reset (asynchronous): out_valid=0, op=0, a=b=imm=npc_out=0, rd=0; all registers cleared to 0
- Reset released mid-transfer: no in-flight instruction survives; the first accept occurs no earlier than the first edge after deassertion
- Simultaneous wb_en and read of the same register: see Configuration
- flush combined with out_ready=0: the held entry is still killed

## Configuration
- DECODE_BYPASS_EN defined: a read of R[x] with wb_en=1, wb_addr=x, x≠0 returns wb_data in the same cycle, so the accepted operand holds the new value
- Not defined: the read returns the pre-write value. The write still lands at the edge; software or hazard logic upstream must space dependent instructions.

## Test plan
- Reset, then wb writes R3=0x11, R4=0x22; accept R-R with Rj=3, Rk=4 -> next cycle out_valid=1, a=0x11, b=0x22, imm=0
- BEQ with ir[15:0]=0xFFFE -> imm=0xFFFF_FFFE; JMP ir[25:0]=0x3FF_FFFF -> imm=0x03FF_FFFF, a=b=0
- LW with rd=5, then R-R reading Rj=5 while out_ready=1 -> in_ready=0 for one cycle, one bubble (out_valid=0), then dependent instruction issued; same sequence with Rj=0 -> no stall
- out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; release -> one instruction per cycle resumes
- wb_en=1, wb_addr=7, wb_data=0xAB in the same cycle an instruction reading R7 is accepted -> a=0xAB with DECODE_BYPASS_EN, old R7 without; wb to R0 -> R0 still reads 0
- flush while out_valid=1, out_ready=0, in_valid=1 -> out_valid=0 next cycle, incoming instruction dropped; async rst mid-stream -> all outputs 0 immediately

Source files
------------

// File: rtl/decode_pipe_if.sv
// Handshake and write-back bundle for the decode_pipe ID stage.
// The master side is the fetch/execute/write-back environment; the slave side is the stage itself.
interface decode_pipe_if #(
   parameter int DW  = 32,
   parameter int RAW = 5
);
   logic           in_valid;
   logic           in_ready;
   logic [31:0]    ir;
   logic [DW-1:0]  npc_in;
   logic           flush;
   logic           out_valid;
   logic           out_ready;
   logic [5:0]     op;
   logic [DW-1:0]  a;
   logic [DW-1:0]  b;
   logic [DW-1:0]  imm;
   logic [DW-1:0]  npc_out;
   logic [RAW-1:0] rd;
   logic           wb_en;
   logic [RAW-1:0] wb_addr;
   logic [DW-1:0]  wb_data;

   modport master (
      output in_valid, ir, npc_in, flush, out_ready, wb_en, wb_addr, wb_data,
      input  in_ready, out_valid, op, a, b, imm, npc_out, rd
   );

   modport slave (
      input  in_valid, ir, npc_in, flush, out_ready, wb_en, wb_addr, wb_data,
      output in_ready, out_valid, op, a, b, imm, npc_out, rd
   );
endinterface

// File: rtl/decode_pipe.sv
// Instruction decode stage: register file, operand/immediate select, load-use stall and ID/EX register.
// Define DECODE_BYPASS_EN to forward same-cycle write-back data onto operand reads.
module decode_pipe #(
   parameter int DW  = 32,
   parameter int RAW = 5
) (
   input logic          clk,
   input logic          rst,
   decode_pipe_if.slave bus
);
   localparam int NREG = 2 ** RAW;

   localparam logic [5:0] OP_LW  = 6'b01_0000;
   localparam logic [5:0] OP_BEQ = 6'b10_0000;
   localparam logic [5:0] OP_JMP = 6'b10_0001;

   logic [DW-1:0] rf_q [NREG];

   logic [5:0]     op_in;
   logic [RAW-1:0] ri, rj, rk;
   logic           is_rr, is_mem, is_beq, is_jmp;
   logic [DW-1:0]  val_ri, val_rj, val_rk;
   logic [DW-1:0]  a_d, b_d, imm_d;
   logic           hz;
   logic           accept;

   logic           out_valid_q;
   logic [5:0]     op_q;
   logic [DW-1:0]  a_q, b_q, imm_q, npc_q;
   logic [RAW-1:0] rd_q;

   assign op_in  = bus.ir[31:26];
   assign ri     = bus.ir[21 +: RAW];
   assign rj     = bus.ir[16 +: RAW];
   assign rk     = bus.ir[11 +: RAW];
   assign is_rr  = (op_in[5:4] == 2'b00);
   assign is_mem = (op_in[5:4] == 2'b01);
   assign is_beq = (op_in == OP_BEQ);
   assign is_jmp = (op_in == OP_JMP);

   // NOTE: the register file is small enough to live in flops, so it takes the async reset like any other state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (bus.wb_en && (bus.wb_addr != '0)) begin
         rf_q[bus.wb_addr] <= bus.wb_data;
      end
   end

   function automatic logic [DW-1:0] read_reg(input logic [RAW-1:0] addr,
                                              input logic            wen,
                                              input logic [RAW-1:0] waddr,
                                              input logic [DW-1:0]  wdata);
      logic [DW-1:0] v;
      v = (addr == '0) ? '0 : rf_q[addr];
`ifdef DECODE_BYPASS_EN
      if (wen && (waddr == addr) && (addr != '0)) v = wdata;
`else
      if (wen && (waddr == addr) && (wdata == '0)) v = v;
`endif
      return v;
   endfunction

   assign val_ri = read_reg(ri, bus.wb_en, bus.wb_addr, bus.wb_data);
   assign val_rj = read_reg(rj, bus.wb_en, bus.wb_addr, bus.wb_data);
   assign val_rk = read_reg(rk, bus.wb_en, bus.wb_addr, bus.wb_data);

   // NOTE: every always_comb output gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      a_d   = '0;
      b_d   = '0;
      imm_d = '0;
      if (is_rr) begin
         a_d = val_rj;
         b_d = val_rk;
      end else if (is_mem || is_beq) begin
         a_d   = val_ri;
         b_d   = val_rj;
         imm_d = {{(DW-16){bus.ir[15]}}, bus.ir[15:0]};
      end else if (is_jmp) begin
         imm_d = {{(DW-26){1'b0}}, bus.ir[25:0]};
      end
   end

   // A held LW stalls only an instruction that actually reads its destination.
   always_comb begin
      hz = 1'b0;
      if (out_valid_q && (op_q == OP_LW) && (rd_q != '0)) begin
         if (is_rr)
            hz = (rd_q == rj) || (rd_q == rk);
         else if (is_mem || is_beq)
            hz = (rd_q == ri) || (rd_q == rj);
      end
   end

   assign bus.in_ready = bus.flush | ((!out_valid_q | bus.out_ready) & !hz);
   assign accept       = bus.in_valid & bus.in_ready;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         imm_q       <= '0;
         npc_q       <= '0;
         rd_q        <= '0;
      end else if (bus.flush) begin
         out_valid_q <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         op_q        <= op_in;
         a_q         <= a_d;
         b_q         <= b_d;
         imm_q       <= imm_d;
         npc_q       <= bus.npc_in;
         rd_q        <= ri;
      end else if (bus.out_ready && out_valid_q) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.op        = op_q;
   assign bus.a         = a_q;
   assign bus.b         = b_q;
   assign bus.imm       = imm_q;
   assign bus.npc_out   = npc_q;
   assign bus.rd        = rd_q;
endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: the driver queues expected ID/EX entries on accept,
// a monitor pops and compares them whenever the stage hands an entry to execute.
module tb_decode_pipe;
   localparam int DW  = 32;
   localparam int RAW = 5;

`ifdef DECODE_BYPASS_EN
   localparam logic [31:0] BYP_R7 = 32'hAB;
`else
   localparam logic [31:0] BYP_R7 = 32'h0;
`endif

   typedef struct packed {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [31:0] npc;
      logic [4:0]  rd;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb [$];

   decode_pipe_if #(.DW(DW), .RAW(RAW)) bus ();

   decode_pipe #(.DW(DW), .RAW(RAW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] ri,
                                         input logic [4:0] rj, input logic [4:0] rk);
      return {op, ri, rj, rk, 11'h155};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] ri,
                                         input logic [4:0] rj, input logic [15:0] im);
      return {op, ri, rj, im};
   endfunction

   function automatic exp_t mk(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic [31:0] npc, input logic [4:0] rd);
      exp_t e;
      e.op = op; e.a = a; e.b = b; e.imm = imm; e.npc = npc; e.rd = rd;
      return e;
   endfunction

   // Starts and ends at posedge+1; waits a bounded number of cycles for in_ready.
   task automatic issue(input logic [31:0] ir, input logic [31:0] npc, input exp_t e, output int stalls);
      bus.in_valid = 1'b1;
      bus.ir       = ir;
      bus.npc_in   = npc;
      stalls       = 0;
      @(negedge clk);
      while (!bus.in_ready && stalls < 20) begin
         stalls++;
         @(negedge clk);
      end
      check("issue_ready", {31'b0, bus.in_ready}, 32'd1);
      if (bus.in_ready) sb.push_back(e);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wb(input logic [4:0] addr, input logic [31:0] data);
      bus.wb_en   = 1'b1;
      bus.wb_addr = addr;
      bus.wb_data = data;
      @(posedge clk); #1;
      bus.wb_en   = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 32'd0, 32'd1);
            end else begin
               e = sb.pop_front();
               check("out_op",  {26'b0, bus.op}, {26'b0, e.op});
               check("out_a",   bus.a,       e.a);
               check("out_b",   bus.b,       e.b);
               check("out_imm", bus.imm,     e.imm);
               check("out_npc", bus.npc_out, e.npc);
               check("out_rd",  {27'b0, bus.rd}, {27'b0, e.rd});
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : driver
      int st;
      bus.in_valid  = 1'b0;
      bus.ir        = '0;
      bus.npc_in    = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      bus.wb_en     = 1'b0;
      bus.wb_addr   = '0;
      bus.wb_data   = '0;

      #2;
      check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("rst_op",  {26'b0, bus.op}, 32'd0);
      check("rst_a",   bus.a, 32'd0);
      check("rst_b",   bus.b, 32'd0);
      check("rst_imm", bus.imm, 32'd0);
      check("rst_npc", bus.npc_out, 32'd0);
      check("rst_rd",  {27'b0, bus.rd}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic R-R, BEQ, JMP
      wb(5'd3, 32'h11);
      wb(5'd4, 32'h22);
      issue(enc_r(6'b00_0010, 5'd2, 5'd3, 5'd4), 32'h100, mk(6'b00_0010, 32'h11, 32'h22, 32'h0, 32'h100, 5'd2), st);
      issue(enc_i(6'b10_0000, 5'd3, 5'd4, 16'hFFFE), 32'h104, mk(6'b10_0000, 32'h11, 32'h22, 32'hFFFF_FFFE, 32'h104, 5'd3), st);
      issue({6'b10_0001, 26'h3FF_FFFF}, 32'h108, mk(6'b10_0001, 32'h0, 32'h0, 32'h03FF_FFFF, 32'h108, 5'd31), st);
      check("b2b_stalls", st, 32'd0);

      // Load-use hazard: exactly one bubble
      wb(5'd5, 32'h55);
      issue(enc_i(6'b01_0000, 5'd5, 5'd4, 16'h0008), 32'h10C, mk(6'b01_0000, 32'h55, 32'h22, 32'h8, 32'h10C, 5'd5), st);
      bus.in_valid = 1'b1;
      bus.ir       = enc_r(6'b00_0001, 5'd6, 5'd5, 5'd3);
      bus.npc_in   = 32'h110;
      @(negedge clk);
      check("hz_in_ready", {31'b0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("hz_bubble_valid", {31'b0, bus.out_valid}, 32'd0);
      check("hz_bubble_ready", {31'b0, bus.in_ready}, 32'd1);
      if (bus.in_ready) sb.push_back(mk(6'b00_0001, 32'h55, 32'h11, 32'h0, 32'h110, 5'd6));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("hz_issued", {31'b0, bus.out_valid}, 32'd1);

      // Same LW, dependent reads r0 only: no stall
      issue(enc_i(6'b01_0000, 5'd5, 5'd4, 16'h0008), 32'h114, mk(6'b01_0000, 32'h55, 32'h22, 32'h8, 32'h114, 5'd5), st);
      issue(enc_r(6'b00_0001, 5'd6, 5'd0, 5'd3), 32'h118, mk(6'b00_0001, 32'h0, 32'h11, 32'h0, 32'h118, 5'd6), st);
      check("nohz_stalls", st, 32'd0);

      // Back-pressure
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      issue(enc_r(6'b00_0001, 5'd1, 5'd3, 5'd4), 32'h200, mk(6'b00_0001, 32'h11, 32'h22, 32'h0, 32'h200, 5'd1), st);
      bus.in_valid = 1'b1;
      bus.ir       = enc_r(6'b00_0011, 5'd2, 5'd4, 5'd3);
      bus.npc_in   = 32'h204;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
         check("bp_hold_a",   bus.a, 32'h11);
         check("bp_hold_npc", bus.npc_out, 32'h200);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      issue(enc_r(6'b00_0011, 5'd2, 5'd4, 5'd3), 32'h204, mk(6'b00_0011, 32'h22, 32'h11, 32'h0, 32'h204, 5'd2), st);
      check("bp_release_stalls", st, 32'd0);
      issue(enc_i(6'b01_0001, 5'd4, 5'd3, 16'h8000), 32'h208, mk(6'b01_0001, 32'h22, 32'h11, 32'hFFFF_8000, 32'h208, 5'd4), st);
      check("bp_resume_stalls", st, 32'd0);

      // Write-back in the same cycle as a read of R7, then R0 writes
      bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'hAB;
      issue(enc_r(6'b00_0000, 5'd1, 5'd7, 5'd0), 32'h300, mk(6'b00_0000, BYP_R7, 32'h0, 32'h0, 32'h300, 5'd1), st);
      bus.wb_en = 1'b0;
      issue(enc_r(6'b00_0000, 5'd1, 5'd7, 5'd0), 32'h304, mk(6'b00_0000, 32'hAB, 32'h0, 32'h0, 32'h304, 5'd1), st);
      bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h99;
      issue(enc_r(6'b00_0000, 5'd1, 5'd0, 5'd7), 32'h308, mk(6'b00_0000, 32'h0, 32'hAB, 32'h0, 32'h308, 5'd1), st);
      bus.wb_en = 1'b0;
      issue(enc_i(6'b01_0000, 5'd0, 5'd7, 16'h0001), 32'h30C, mk(6'b01_0000, 32'h0, 32'hAB, 32'h1, 32'h30C, 5'd0), st);

      // Flush with out_ready low kills the held entry and the incoming one
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      issue(enc_r(6'b00_0001, 5'd1, 5'd3, 5'd4), 32'h400, mk(6'b00_0001, 32'h11, 32'h22, 32'h0, 32'h400, 5'd1), st);
      bus.in_valid = 1'b1;
      bus.ir       = enc_r(6'b00_0010, 5'd2, 5'd4, 5'd4);
      bus.npc_in   = 32'h404;
      bus.flush    = 1'b1;
      @(negedge clk);
      check("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
      check("flush_pre_valid", {31'b0, bus.out_valid}, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
      @(posedge clk); #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_kill", {31'b0, bus.out_valid}, 32'd0);
      bus.out_ready = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      check("flush_drop", {31'b0, bus.out_valid}, 32'd0);

      // Asynchronous reset mid-stream
      bus.out_ready = 1'b0;
      issue(enc_i(6'b01_0000, 5'd9, 5'd3, 16'h1234), 32'h500, mk(6'b01_0000, 32'h0, 32'h11, 32'h1234, 32'h500, 5'd9), st);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", {31'b0, bus.out_valid}, 32'd0);
      check("arst_op",  {26'b0, bus.op}, 32'd0);
      check("arst_b",   bus.b, 32'd0);
      check("arst_imm", bus.imm, 32'd0);
      check("arst_npc", bus.npc_out, 32'd0);
      check("arst_rd",  {27'b0, bus.rd}, 32'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      issue(enc_r(6'b00_0010, 5'd2, 5'd3, 5'd4), 32'h600, mk(6'b00_0010, 32'h0, 32'h0, 32'h0, 32'h600, 5'd2), st);

      repeat (3) begin @(posedge clk); #1; end
      check("sb_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
